// File: rtl/wpa2_nios2_mul_pkg.sv
// Shared definitions for the M-stage multiply combine path: op codes, FSM states
// and the arithmetic helpers that merge the 16x16 partial products.
package wpa2_nios2_mul_pkg;

    localparam int HI_ITER = 16;
    localparam int OP_W    = 2;
    localparam int CNT_W   = $clog2(HI_ITER);

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIMUL = 2'd1,
        ST_SUM   = 2'd2,
        ST_CORR  = 2'd3
    } state_e;

    // Low word: the cross products only reach the low word through their low halves.
    function automatic logic [31:0] combine_lo(input logic [31:0] p1,
                                               input logic [31:0] p2,
                                               input logic [31:0] p3);
        combine_lo = p1 + ((p2 + p3) << 16);
    endfunction

    // Unsigned high word; the 33-bit cross sum keeps the carry that feeds bit 48.
    function automatic logic [31:0] combine_hi(input logic [31:0] p1,
                                               input logic [31:0] p2,
                                               input logic [31:0] p3,
                                               input logic [31:0] hh);
        logic [32:0] mid;
        logic [63:0] full;
        mid  = {1'b0, p2} + {1'b0, p3};
        full = {32'h0, p1} + {15'h0, mid, 16'h0} + {hh, 32'h0};
        combine_hi = full[63:32];
    endfunction

    function automatic logic [31:0] correct_hi(input logic [31:0] hi,
                                               input op_e         op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] sub_a;
        logic [31:0] sub_b;
        sub_a = a[31] ? b : 32'h0;
        sub_b = b[31] ? a : 32'h0;
        case (op)
            OP_MULXSU: correct_hi = hi - sub_a;
            OP_MULXSS: correct_hi = hi - sub_a - sub_b;
            default:   correct_hi = hi;
        endcase
    endfunction

endpackage

// File: rtl/wpa2_nios2_fast_cpu_mul_hi16.sv
// Radix-2 shift-add 16x16 unsigned multiplier; one multiplier bit per cycle,
// done pulses the cycle after the last bit has been accumulated.
module wpa2_nios2_fast_cpu_mul_hi16
    import wpa2_nios2_mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0]      r_mcand;
    logic [15:0]      r_mplier;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_mcand  <= 32'h0;
            r_mplier <= 16'h0;
            r_acc    <= 32'h0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_mcand  <= {16'h0, a};
                r_mplier <= b;
                r_acc    <= 32'h0;
                r_cnt    <= '0;
                r_run    <= 1'b1;
            end else if (r_run) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(HI_ITER - 1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/wpa2_nios2_fast_cpu_mul_combine.sv
// Combines the M-stage partial products into the MUL low word in one cycle, or
// the MULX* high word after an iterative hi*hi product and signed correction.
module wpa2_nios2_fast_cpu_mul_combine
    import wpa2_nios2_mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] M_src1,
    input  logic [31:0] M_src2,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    input  logic        flush,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result
);

    state_e           r_state;
    logic [CNT_W-1:0] r_counter;
    op_e              r_op;
    logic [31:0]      r_p1;
    logic [31:0]      r_p2;
    logic [31:0]      r_p3;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_result;
    logic             r_result_valid;
    logic             r_busy;

    state_e           w_state_next;
    logic             w_accept_mul;
    logic             w_accept_mulx;
    logic             w_hi_done;
    logic [31:0]      w_hi_product;

    always_comb begin
        w_state_next  = r_state;
        w_accept_mul  = 1'b0;
        w_accept_mulx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_busy is still high in the cycle the MULX result is presented
                if (in_valid && !r_busy) begin
                    if (op_e'(op) == OP_MUL) begin
                        w_accept_mul = 1'b1;
                    end else begin
                        w_accept_mulx = 1'b1;
                        w_state_next  = ST_HIMUL;
                    end
                end
            end
            ST_HIMUL: begin
                if (r_counter == CNT_W'(HI_ITER - 1)) begin
                    w_state_next = ST_SUM;
                end
            end
            ST_SUM:  w_state_next = ST_CORR;
            ST_CORR: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next  = ST_IDLE;
            w_accept_mul  = 1'b0;
            w_accept_mulx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_counter      <= '0;
            r_op           <= OP_MUL;
            r_p1           <= 32'h0;
            r_p2           <= 32'h0;
            r_p3           <= 32'h0;
            r_a            <= 32'h0;
            r_b            <= 32'h0;
            r_hi           <= 32'h0;
            r_result       <= 32'h0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_result_valid <= 1'b0;
            r_busy         <= !flush && ((w_state_next != ST_IDLE) || (r_state == ST_CORR));

            if (r_state == ST_HIMUL && w_state_next == ST_HIMUL) begin
                r_counter <= r_counter + CNT_W'(1);
            end else begin
                r_counter <= '0;
            end

            if (w_accept_mul) begin
                r_result       <= combine_lo(M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3);
                r_result_valid <= 1'b1;
            end

            if (w_accept_mulx) begin
                r_op <= op_e'(op);
                r_p1 <= M_mul_cell_p1;
                r_p2 <= M_mul_cell_p2;
                r_p3 <= M_mul_cell_p3;
                r_a  <= M_src1;
                r_b  <= M_src2;
            end

            if (r_state == ST_SUM && w_hi_done && !flush) begin
                r_hi <= combine_hi(r_p1, r_p2, r_p3, w_hi_product);
            end

            if (r_state == ST_CORR && !flush) begin
                r_result       <= correct_hi(r_hi, r_op, r_a, r_b);
                r_result_valid <= 1'b1;
            end
        end
    end

    wpa2_nios2_fast_cpu_mul_hi16 u_hi16 (
        .clk     (clk),
        .reset   (reset),
        .start   (w_accept_mulx),
        .flush   (flush),
        .a       (M_src1[31:16]),
        .b       (M_src2[31:16]),
        .done    (w_hi_done),
        .product (w_hi_product)
    );

    assign busy         = r_busy;
    assign in_ready     = ~r_busy;
    assign result_valid = r_result_valid;
    assign result       = r_result;

endmodule

// File: tb/tb_wpa2_nios2_fast_cpu_mul_combine.sv
// Directed and random checks of the multiply combine block against a 64-bit
// arithmetic reference model.
module tb_wpa2_nios2_fast_cpu_mul_combine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] M_src1;
    logic [31:0] M_src2;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic        flush;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    wpa2_nios2_fast_cpu_mul_combine dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .M_src1        (M_src1),
        .M_src2        (M_src2),
        .M_mul_cell_p1 (p1),
        .M_mul_cell_p2 (p2),
        .M_mul_cell_p3 (p3),
        .flush         (flush),
        .busy          (busy),
        .result_valid  (result_valid),
        .result        (result)
    );

    function automatic logic [31:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        prod;
        case (o)
            2'b00: begin
                prod = {32'h0, a} * {32'h0, b};
                ref_result = prod[31:0];
            end
            2'b01: begin
                prod = {32'h0, a} * {32'h0, b};
                ref_result = prod[63:32];
            end
            2'b10: begin
                sa = $signed({{32{a[31]}}, a});
                sb = $signed({32'h0, b});
                prod = sa * sb;
                ref_result = prod[63:32];
            end
            default: begin
                sa = $signed({{32{a[31]}}, a});
                sb = $signed({{32{b[31]}}, b});
                prod = sa * sb;
                ref_result = prod[63:32];
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        M_src1   = a;
        M_src2   = b;
        p1       = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
        p2       = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
        p3       = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        in_valid = 1'b1;
    endtask

    // Issue one request at a negedge and follow it to its result strobe.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int intrude);
        int  exp_lat;
        logic seen;
        logic mulx;
        mulx    = (o != 2'b00);
        exp_lat = mulx ? 19 : 1;
        seen    = 1'b0;
        drive_req(o, a, b);
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (intrude != 0 && cyc == intrude) drive_req(2'b00, $urandom, $urandom);
            if (cyc == intrude + 1) in_valid = 1'b0;
            check({tag, "_busy"}, 32'(busy), 32'(mulx && cyc <= 19));
            check({tag, "_in_ready"}, 32'(in_ready), 32'(!(mulx && cyc <= 19)));
            if (result_valid) begin
                check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
                check({tag, "_result"}, result, exp);
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(result_valid), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, result, exp);
        $display("txn %s op=%0d a=%h b=%h result=%h expected=%h", tag, o, a, b, result, exp);
        last_result = exp;
    endtask

    initial begin
        logic seen_valid;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        op       = 2'b00;
        M_src1   = 32'h0;
        M_src2   = 32'h0;
        p1       = 32'h0;
        p2       = 32'h0;
        p3       = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        last_result = 32'h0;

        run_op("mul_basic",   2'b00, 32'h00030002, 32'h00050004, 32'h00160008, 0);
        run_op("mulxuu_basic", 2'b01, 32'h00030002, 32'h00050004, 32'h0000000F, 0);
        run_op("mulxuu_ones", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("mulxss_ones", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
        run_op("mulxsu_ones", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("mulxss_min_max", 2'b11, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 0);
        run_op("mulxss_min_min", 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 0);

        // Flush at T+8 of a MULXUU: no result, prior result retained.
        drive_req(2'b01, 32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(result_valid), 32'd0);
        check("flush_result", result, last_result);
        seen_valid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen_valid = seen_valid | result_valid;
        end
        check("flush_no_late_valid", 32'(seen_valid), 32'd0);
        $display("txn flush_mulxuu result=%h retained=%h", result, last_result);
        run_op("mul_after_flush", 2'b00, 32'hDEADBEEF, 32'h00001234,
               ref_result(2'b00, 32'hDEADBEEF, 32'h00001234), 0);

        // Flush beats a same-cycle MUL request.
        drive_req(2'b00, 32'h0000FFFF, 32'h0000FFFF);
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_mul_valid", 32'(result_valid), 32'd0);
        check("flush_mul_result", result, last_result);
        $display("txn flush_mul_dropped result=%h", result);

        // Reset in the middle of HIMUL.
        drive_req(2'b11, 32'hCAFEBABE, 32'h87654321);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen_valid = seen_valid | result_valid;
        end
        check("midrst_no_valid", 32'(seen_valid), 32'd0);
        $display("txn reset_mid_himul result=%h", result);
        last_result = 32'h0;

        // A request presented while busy must be ignored.
        run_op("ignore_while_busy", 2'b11, 32'hF0F01234, 32'h0FF0ABCD,
               ref_result(2'b11, 32'hF0F01234, 32'h0FF0ABCD), 6);

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) ra = {1'b1, ra[30:0]};
            if (i % 7 == 0) rb = {1'b1, rb[30:0]};
            run_op($sformatf("rand%0d", i), ro, ra, rb, ref_result(ro, ra, rb), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
